// File: rtl/ahb_bus_control_if.sv
// Core request/response port and AHB-Lite master signals, grouped so the
// bridge and its environment share one bundle. The "master" modport is the
// bridge's view. The "slave" modport is the view of the core plus the
// attached slaves.
interface ahb_bus_control_if #(
    parameter int DEVICE_COUNT = 2
);
    // core side
    logic                        req_valid;
    logic                        req_write;
    logic                        req_instr;
    logic [31:0]                 req_addr;
    logic [2:0]                  req_size;
    logic [31:0]                 req_wdata;
    logic                        req_ready;
    logic                        rsp_valid;
    logic [31:0]                 rsp_rdata;
    logic                        rsp_error;

    // AHB side
    logic [31:0]                 haddr;
    logic                        hwrite;
    logic [2:0]                  hsize;
    logic [2:0]                  hburst;
    logic [3:0]                  hprot;
    logic [1:0]                  htrans;
    logic                        hmastlock;
    logic                        hready;
    logic [31:0]                 hwdata;
    logic [DEVICE_COUNT-1:0]     hsel;
    logic [DEVICE_COUNT*32-1:0]  hrdata;
    logic [DEVICE_COUNT-1:0]     hreadyout;
    logic [DEVICE_COUNT-1:0]     hresp;

    modport master (
        input  req_valid, req_write, req_instr, req_addr, req_size, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock,
        output hready, hwdata, hsel,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        output req_valid, req_write, req_instr, req_addr, req_size, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock,
        input  hready, hwdata, hsel,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_bus_control.sv
// Single-master AHB-Lite bridge. It takes the core's request port and drives
// one SINGLE transfer at a time onto a shared bus with DEVICE_COUNT slaves.
// The address phase is driven combinationally in the accepting cycle. The
// response is muxed combinationally from the selected slave.
//
// state  | meaning
// S_IDLE | ready for a request; address phase driven when one arrives
// S_DATA | data phase of the accepted transfer; waits on hreadyout
// S_ERR2 | second cycle of a two-cycle ERROR, or pending misaligned reply
module ahb_bus_control #(
    parameter int                            DEVICE_COUNT = 2,
    parameter logic [(DEVICE_COUNT-1)*32-1:0] ADDR_MAP    = {32'd2048}
) (
    input  logic               clk,
    input  logic               rst,
    ahb_bus_control_if.master  bus
);
    localparam int SW = (DEVICE_COUNT > 1) ? $clog2(DEVICE_COUNT) : 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_ERR2
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  sel_q, sel_d;
    logic           write_q, write_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           mis_q, mis_d;

    logic [31:0]    haddr_c;
    logic           hwrite_c;
    logic [2:0]     hsize_c;
    logic [3:0]     hprot_c;
    logic [1:0]     htrans_c;
    logic           hready_c;
    logic           req_ready_c;
    logic           rsp_valid_c;
    logic [31:0]    rsp_rdata_c;
    logic           rsp_error_c;
    logic [DEVICE_COUNT-1:0] hsel_c;

    logic           slave_ready;
    logic           slave_resp;
    logic [31:0]    slave_rdata;
    logic           misaligned;

    // Region decode: the highest boundary not above addr picks the device.
    function automatic logic [SW-1:0] decode(input logic [31:0] addr);
        logic [SW-1:0] idx;
        idx = '0;
        for (int k = 0; k < DEVICE_COUNT - 1; k++) begin
            if (addr >= ADDR_MAP[32*k +: 32]) begin
                idx = SW'(k + 1);
            end
        end
        return idx;
    endfunction

    assign slave_ready = bus.hreadyout[sel_q];
    assign slave_resp  = bus.hresp[sel_q];
    assign slave_rdata = bus.hrdata[32*sel_q +: 32];

    assign misaligned = ((bus.req_size == 3'd1) && bus.req_addr[0]) ||
                        ((bus.req_size == 3'd2) && (bus.req_addr[1:0] != 2'b00));

    // Next-state logic and all bus/response outputs; everything is forced to
    // its reset value while rst is low so that reset takes effect at once.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        mis_d       = mis_q;
        haddr_c     = '0;
        hwrite_c    = 1'b0;
        hsize_c     = '0;
        hprot_c     = '0;
        htrans_c    = HTRANS_IDLE;
        hready_c    = 1'b1;
        req_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        rsp_rdata_c = '0;
        rsp_error_c = 1'b0;
        if (rst) begin
            case (state_q)
                S_IDLE: begin
                    req_ready_c = 1'b1;
                    if (bus.req_valid) begin
                        if (misaligned) begin
                            // Accepted without a bus transfer; reply next cycle.
                            mis_d   = 1'b1;
                            state_d = S_ERR2;
                        end else begin
                            htrans_c = HTRANS_NONSEQ;
                            haddr_c  = bus.req_addr;
                            hwrite_c = bus.req_write;
                            hsize_c  = bus.req_size;
                            hprot_c  = {2'b00, 1'b1, ~bus.req_instr};
                            sel_d    = decode(bus.req_addr);
                            write_d  = bus.req_write;
                            wdata_d  = bus.req_wdata;
                            mis_d    = 1'b0;
                            state_d  = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    hready_c = slave_ready;
                    if (slave_ready) begin
                        // A one-cycle ERROR from a non-compliant slave still ends the transfer.
                        rsp_valid_c = 1'b1;
                        rsp_error_c = slave_resp;
                        if (!slave_resp && !write_q) begin
                            rsp_rdata_c = slave_rdata;
                        end
                        state_d = S_IDLE;
                    end else if (slave_resp) begin
                        state_d = S_ERR2;
                    end
                end
                S_ERR2: begin
                    if (mis_q) begin
                        rsp_valid_c = 1'b1;
                        rsp_error_c = 1'b1;
                        mis_d       = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        hready_c = slave_ready;
                        if (slave_ready) begin
                            rsp_valid_c = 1'b1;
                            rsp_error_c = 1'b1;
                            state_d     = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Slave select follows the address on haddr, only during NONSEQ.
    always_comb begin
        hsel_c = '0;
        if (htrans_c == HTRANS_NONSEQ) begin
            hsel_c = DEVICE_COUNT'(1) << decode(haddr_c);
        end
    end

    // Transfer context held across the data phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_rdata = rsp_rdata_c;
    assign bus.rsp_error = rsp_error_c;
    assign bus.haddr     = haddr_c;
    assign bus.hwrite    = hwrite_c;
    assign bus.hsize     = hsize_c;
    assign bus.hburst    = 3'b000;
    assign bus.hprot     = hprot_c;
    assign bus.htrans    = htrans_c;
    assign bus.hmastlock = 1'b0;
    assign bus.hready    = hready_c;
    assign bus.hwdata    = wdata_q;
    assign bus.hsel      = hsel_c;
endmodule

// File: tb/tb_ahb_bus_control.sv
module tb_ahb_bus_control;
    logic clk;
    logic rst;

    ahb_bus_control_if #(.DEVICE_COUNT(2)) bus ();

    ahb_bus_control #(
        .DEVICE_COUNT(2),
        .ADDR_MAP    ({32'd2048})
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic        instr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] sdata;   // dev0 returns sdata, dev1 returns ~sdata
        int          dev;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        error;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Compare the response visible in the current cycle with the scoreboard head.
    task automatic expect_rsp(input string name);
        exp_t e;
        chk({name, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", name);
        end else begin
            e = exp_q.pop_front();
            chk({name, " rsp_rdata"}, bus.rsp_rdata, e.rdata);
            chk({name, " rsp_error"}, 32'(bus.rsp_error), 32'(e.error));
        end
    endtask

    task automatic set_slaves(input logic [31:0] d);
        bus.hrdata[31:0]  = d;
        bus.hrdata[63:32] = ~d;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        logic [31:0] rd;
        string nm;
        nm = $sformatf("vec%0d", idx);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = v.write;
        bus.req_instr = v.instr;
        bus.req_addr  = v.addr;
        bus.req_size  = v.size;
        bus.req_wdata = v.wdata;
        set_slaves(v.sdata);
        bus.hreadyout = 2'b11;
        bus.hresp     = 2'b00;
        #1;
        chk({nm, " req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({nm, " htrans"}, 32'(bus.htrans), 32'd2);
        chk({nm, " hsel"}, 32'(bus.hsel), (v.dev == 1) ? 32'd2 : 32'd1);
        chk({nm, " haddr"}, bus.haddr, v.addr);
        chk({nm, " hwrite"}, 32'(bus.hwrite), 32'(v.write));
        chk({nm, " hsize"}, 32'(bus.hsize), 32'(v.size));
        chk({nm, " hprot"}, 32'(bus.hprot), 32'({3'b001, ~v.instr}));
        rd = v.write ? 32'h0 : ((v.dev == 1) ? ~v.sdata : v.sdata);
        e.rdata = rd;
        e.error = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk({nm, " data htrans"}, 32'(bus.htrans), 32'd0);
        chk({nm, " data hsel"}, 32'(bus.hsel), 32'd0);
        chk({nm, " data req_ready"}, 32'(bus.req_ready), 32'd0);
        if (v.write) chk({nm, " hwdata"}, bus.hwdata, v.wdata);
        expect_rsp(nm);
    endtask

    vec_t vecs[7];

    initial begin
        exp_t e;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 3'd2, 32'h0,         32'h1234_5678, 0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0800, 3'd2, 32'hDEAD_BEEF, 32'h5555_AAAA, 1};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_07FF, 3'd0, 32'h0,         32'h0000_00A5, 0};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0800, 3'd2, 32'h0,         32'h0F0F_0F0F, 1};
        vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 3'd2, 32'h0,         32'h1357_9BDF, 1};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_07FE, 3'd1, 32'h0000_BEEF, 32'h2222_3333, 0};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0802, 3'd1, 32'h0,         32'h8765_4321, 1};

        rst           = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_instr = 1'b0;
        bus.req_addr  = 32'h0000_0100;
        bus.req_size  = 3'd2;
        bus.req_wdata = 32'hFFFF_FFFF;
        set_slaves(32'hAAAA_5555);
        bus.hreadyout = 2'b11;
        bus.hresp     = 2'b00;

        // Reset state, with a request pending to show it is ignored.
        @(negedge clk);
        #1;
        chk("rst req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst htrans", 32'(bus.htrans), 32'd0);
        chk("rst hsel", 32'(bus.hsel), 32'd0);
        chk("rst haddr", bus.haddr, 32'd0);
        chk("rst hwrite", 32'(bus.hwrite), 32'd0);
        chk("rst hprot", 32'(bus.hprot), 32'd0);
        chk("rst hready", 32'(bus.hready), 32'd1);
        chk("rst hburst", 32'(bus.hburst), 32'd0);
        chk("rst hmastlock", 32'(bus.hmastlock), 32'd0);
        chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Wait states: dev0 holds hreadyout low for three data-phase cycles.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_instr = 1'b0;
        bus.req_addr  = 32'h0000_0020;
        bus.req_size  = 3'd2;
        set_slaves(32'hC001_D00D);
        bus.hreadyout = 2'b10;
        #1;
        chk("wait addr htrans", 32'(bus.htrans), 32'd2);
        chk("wait addr hready", 32'(bus.hready), 32'd1);
        e.rdata = 32'hC001_D00D;
        e.error = 1'b0;
        exp_q.push_back(e);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            #1;
            chk($sformatf("wait c%0d hready", i), 32'(bus.hready), 32'd0);
            chk($sformatf("wait c%0d req_ready", i), 32'(bus.req_ready), 32'd0);
            chk($sformatf("wait c%0d rsp_valid", i), 32'(bus.rsp_valid), 32'd0);
        end
        @(negedge clk);
        bus.hreadyout = 2'b11;
        #1;
        expect_rsp("wait c4");
        @(negedge clk);
        #1;
        chk("wait after rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("wait after req_ready", 32'(bus.req_ready), 32'd1);

        // Two-cycle ERROR from dev1.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0900;
        bus.hreadyout = 2'b01;
        bus.hresp     = 2'b10;
        #1;
        chk("err addr htrans", 32'(bus.htrans), 32'd2);
        chk("err addr hsel", 32'(bus.hsel), 32'd2);
        e.rdata = 32'h0;
        e.error = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("err c1 htrans", 32'(bus.htrans), 32'd0);
        chk("err c1 rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("err c1 hready", 32'(bus.hready), 32'd0);
        @(negedge clk);
        bus.hreadyout = 2'b11;
        #1;
        chk("err c2 htrans", 32'(bus.htrans), 32'd0);
        expect_rsp("err c2");
        @(negedge clk);
        bus.hresp = 2'b00;
        #1;
        chk("err after rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("err after req_ready", 32'(bus.req_ready), 32'd1);

        // Misaligned requests: no bus transfer, error reply next cycle.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_write = (i == 1);
            bus.req_addr  = (i == 0) ? 32'h0000_0002 : 32'h0000_0801;
            bus.req_size  = (i == 0) ? 3'd2 : 3'd1;
            #1;
            chk($sformatf("mis%0d htrans", i), 32'(bus.htrans), 32'd0);
            chk($sformatf("mis%0d hsel", i), 32'(bus.hsel), 32'd0);
            chk($sformatf("mis%0d req_ready", i), 32'(bus.req_ready), 32'd1);
            chk($sformatf("mis%0d early rsp", i), 32'(bus.rsp_valid), 32'd0);
            e.rdata = 32'h0;
            e.error = 1'b1;
            exp_q.push_back(e);
            @(negedge clk);
            bus.req_valid = 1'b0;
            #1;
            chk($sformatf("mis%0d rsp req_ready", i), 32'(bus.req_ready), 32'd0);
            chk($sformatf("mis%0d rsp htrans", i), 32'(bus.htrans), 32'd0);
            expect_rsp($sformatf("mis%0d", i));
        end

        // Reset during a stalled write data phase abandons the transfer.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h0000_0044;
        bus.req_size  = 3'd2;
        bus.req_wdata = 32'hCAFE_F00D;
        bus.hreadyout = 2'b10;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("rstmid hwdata before", bus.hwdata, 32'hCAFE_F00D);
        chk("rstmid hready before", 32'(bus.hready), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("rstmid hwdata", bus.hwdata, 32'd0);
        chk("rstmid hready", 32'(bus.hready), 32'd1);
        chk("rstmid req_ready", 32'(bus.req_ready), 32'd0);
        chk("rstmid htrans", 32'(bus.htrans), 32'd0);
        chk("rstmid hsel", 32'(bus.hsel), 32'd0);
        chk("rstmid rsp_valid", 32'(bus.rsp_valid), 32'd0);
        bus.hreadyout = 2'b11;
        @(negedge clk);
        #1;
        chk("rstmid held rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid release req_ready", 32'(bus.req_ready), 32'd1);
        chk("rstmid release rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
